// File: rtl/full_adder_4b.sv
// ---------------------------------------------------------------------------
// full_adder_4b
//   WIDTH-bit ripple-carry adder built from a chain of 1-bit full-adder cells.
//   The sum and carry-out are registered, so the result appears one clock
//   after the operands are sampled. One operation is accepted per cycle; there
//   is no handshake.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      synchronous active-low reset; clears sum and cout
//   a      in   WIDTH  operand A, unsigned
//   b      in   WIDTH  operand B, unsigned
//   cin    in   WIDTH  carry-in; only cin[0] takes part in the addition
//   sum    out  WIDTH  registered (a + b + cin[0]) mod 2**WIDTH
//   cout   out  WIDTH  registered carry-out in bit 0; upper bits are always 0
// ---------------------------------------------------------------------------
module full_adder_4b #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] cin,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] cout
);

    // carry[i] is the carry into cell i; carry[WIDTH] leaves the top cell.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;

    // The upper carry-in bits are deliberately ignored. Folding the whole bus
    // into a sink signal keeps them visibly consumed without letting any X on
    // them reach the datapath.
    logic unused_cin;
    assign unused_cin = ^cin;

    assign carry[0] = cin[0];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            logic prop;
            assign prop         = a[gi] ^ b[gi];
            assign sum_next[gi] = prop ^ carry[gi];
            assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & prop);
        end
    endgenerate

    // Reset wins over the datapath: the operation sampled on a reset edge is
    // dropped rather than delayed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_reg  <= '0;
            cout_reg <= 1'b0;
        end else begin
            sum_reg  <= sum_next;
            cout_reg <= carry[WIDTH];
        end
    end

    assign sum  = sum_reg;
    // Zero-extend the single carry bit to the full port width.
    assign cout = WIDTH'(cout_reg);

endmodule

// File: tb/tb_full_adder_4b.sv
// ---------------------------------------------------------------------------
// tb_full_adder_4b
//   Self-checking bench for full_adder_4b (WIDTH = 4). Operands are driven on
//   the falling edge and the registered result is checked 1 time unit after
//   the next rising edge. Expected results come from fixed vector tables and
//   from a plain-arithmetic reference (a + b + cin[0] as a 5-bit number).
// ---------------------------------------------------------------------------
module tb_full_adder_4b;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] cin;
    logic [W-1:0] sum;
    logic [W-1:0] cout;

    int n_cmp;
    int n_bad;
    int n_txn;

    full_adder_4b #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] vcin;
        logic         vrst_n;
        logic [W-1:0] esum;
        logic [W-1:0] ecout;
    } vec_t;

    vec_t vecs [12];

    // Compare current outputs against expectations; one line per transaction.
    task automatic check(input string name, input logic [W-1:0] esum,
                         input logic [W-1:0] ecout);
        n_cmp++;
        n_txn++;
        if (sum !== esum || cout !== ecout) begin
            n_bad++;
            $display("FAIL %s: a=%0d b=%0d cin=%b rst_n=%b got sum=%0d cout=%0d, want sum=%0d cout=%0d",
                     name, a, b, cin, rst_n, sum, cout, esum, ecout);
        end else begin
            $display("txn %0d %s: a=%0d b=%0d cin=%b rst_n=%b sum=%0d cout=%0d ok",
                     n_txn, name, a, b, cin, rst_n, sum, cout);
        end
    endtask

    // Drive one operation and check the result one clock later.
    task automatic do_op(input string name, input logic [W-1:0] ta,
                         input logic [W-1:0] tb, input logic [W-1:0] tcin,
                         input logic trst_n, input logic [W-1:0] esum,
                         input logic [W-1:0] ecout);
        @(negedge clk);
        a     = ta;
        b     = tb;
        cin   = tcin;
        rst_n = trst_n;
        @(posedge clk);
        #1;
        check(name, esum, ecout);
    endtask

    // Reference: plain integer addition of the operands and the carry-in bit.
    task automatic model_op(input string name, input logic [W-1:0] ta,
                            input logic [W-1:0] tb, input logic [W-1:0] tcin);
        int total;
        logic [W-1:0] es;
        logic [W-1:0] ec;
        total = int'(ta) + int'(tb) + int'(tcin[0]);
        es    = W'(total % (1 << W));
        ec    = (total >= (1 << W)) ? W'(1) : W'(0);
        do_op(name, ta, tb, tcin, 1'b1, es, ec);
    endtask

    initial begin
        logic [W-1:0] held_sum;
        logic [W-1:0] held_cout;

        n_cmp = 0;
        n_bad = 0;
        n_txn = 0;
        rst_n = 1'b0;
        a     = '0;
        b     = '0;
        cin   = '0;

        vecs[0]  = '{4'd1,  4'd1,  4'b0001, 1'b1, 4'd3,  4'd0};
        vecs[1]  = '{4'd4,  4'd2,  4'b0000, 1'b1, 4'd6,  4'd0};
        vecs[2]  = '{4'd3,  4'd3,  4'b0001, 1'b1, 4'd7,  4'd0};
        vecs[3]  = '{4'd4,  4'd4,  4'b0000, 1'b1, 4'd8,  4'd0};
        vecs[4]  = '{4'd2,  4'd4,  4'b0001, 1'b1, 4'd7,  4'd0};
        vecs[5]  = '{4'd15, 4'd15, 4'b0001, 1'b1, 4'd15, 4'd1};
        vecs[6]  = '{4'd8,  4'd8,  4'b0000, 1'b1, 4'd0,  4'd1};
        vecs[7]  = '{4'd0,  4'd0,  4'b0000, 1'b1, 4'd0,  4'd0};
        vecs[8]  = '{4'd5,  4'd2,  4'b1110, 1'b1, 4'd7,  4'd0};
        vecs[9]  = '{4'd15, 4'd0,  4'b0001, 1'b1, 4'd0,  4'd1};
        vecs[10] = '{4'd9,  4'd6,  4'b0000, 1'b1, 4'd15, 4'd0};
        vecs[11] = '{4'd7,  4'd9,  4'b1111, 1'b1, 4'd1,  4'd1};

        // Reset held for two cycles with all-ones operands: outputs stay zero.
        do_op("reset0", 4'hF, 4'hF, 4'b0001, 1'b0, 4'd0, 4'd0);
        do_op("reset1", 4'hF, 4'hF, 4'b0001, 1'b0, 4'd0, 4'd0);

        for (int i = 0; i < 12; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb,
                  vecs[i].vcin, vecs[i].vrst_n, vecs[i].esum, vecs[i].ecout);
        end

        // Upper carry-in bits at X must not disturb the result.
        do_op("cin_x", 4'd5, 4'd2, 4'bxxx0, 1'b1, 4'd7, 4'd0);
        do_op("cin_x1", 4'd5, 4'd2, 4'bxxx1, 1'b1, 4'd8, 4'd0);

        // Reset mid-stream: third edge is a reset edge and discards a=3.
        do_op("mid1", 4'd1, 4'd1, 4'b0000, 1'b1, 4'd2, 4'd0);
        do_op("mid2", 4'd2, 4'd1, 4'b0000, 1'b1, 4'd3, 4'd0);
        do_op("mid3_rst", 4'd3, 4'd1, 4'b0000, 1'b0, 4'd0, 4'd0);
        do_op("mid4", 4'd4, 4'd1, 4'b0000, 1'b1, 4'd5, 4'd0);
        do_op("mid5", 4'd5, 4'd1, 4'b0000, 1'b1, 4'd6, 4'd0);

        // Glitching rst_n and the operands between edges changes nothing.
        held_sum  = 4'd6;
        held_cout = 4'd0;
        @(negedge clk);
        rst_n = 1'b0;
        a     = 4'hF;
        b     = 4'hF;
        #2;
        check("async_glitch", held_sum, held_cout);
        rst_n = 1'b1;
        a     = 4'd5;
        b     = 4'd1;
        @(posedge clk);
        #1;
        check("after_glitch", 4'd6, 4'd0);

        // Exhaustive sweep of a, b and cin[0].
        for (int ci = 0; ci < 2; ci++) begin
            for (int ia = 0; ia < 16; ia++) begin
                for (int ib = 0; ib < 16; ib++) begin
                    model_op("sweep", W'(ia), W'(ib), W'(ci));
                end
            end
        end

        // Random operands with random upper carry-in bits.
        for (int r = 0; r < 64; r++) begin
            model_op("rand", W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
                     W'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
